// File: rtl/sysbus_pkg.sv
// Shared Sysbus line-protocol constants, FSM state encoding and tag-field helpers.
package sysbus_pkg;

    localparam int unsigned SYSBUS_BEATS      = 8;
    localparam int unsigned SYSBUS_LINE_BYTES = 64;
    localparam int unsigned SYSBUS_DATA_W     = 64;
    localparam int unsigned SYSBUS_BEAT_W     = $clog2(SYSBUS_BEATS);
    localparam int unsigned SYSBUS_OFFSET_W   = $clog2(SYSBUS_LINE_BYTES);

    typedef logic [SYSBUS_DATA_W-1:0] sysbus_beat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WAIT,
        ST_RESP
    } sysbus_resp_state_t;

    // The write/read direction bit is always the tag MSB.
    function automatic int unsigned sysbus_tag_wr_pos(input int unsigned tag_w);
        return tag_w - 1;
    endfunction

endpackage

// File: rtl/sysbus_mem_responder_line_ram.sv
// Line store: MEM_LINES x 8 beats of 64 bits, one sync write port and one sync read port.
module line_ram
    import sysbus_pkg::*;
#(
    parameter int unsigned MEM_LINES = 1024,
    parameter int unsigned IDX_W     = 10
) (
    input  logic                            clk,
    input  logic                            we,
    input  logic [IDX_W+SYSBUS_BEAT_W-1:0]  waddr,
    input  sysbus_beat_t                    wdata,
    input  logic [IDX_W+SYSBUS_BEAT_W-1:0]  raddr,
    output sysbus_beat_t                    rdata
);

    localparam int unsigned DEPTH = MEM_LINES * SYSBUS_BEATS;

    sysbus_beat_t mem_q [DEPTH];
    sysbus_beat_t rdata_q;

    // Contents are deliberately not reset so they survive a responder reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side Sysbus responder: absorbs 8-beat line writes, returns 8-beat line reads after LATENCY cycles.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int unsigned MEM_LINES = 1024,
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned TAG_W     = 13
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [63:0]      req,
    input  logic [TAG_W-1:0] reqtag,
    input  logic             reqcyc,
    output logic             reqack,
    output logic [63:0]      resp,
    output logic [TAG_W-1:0] resptag,
    output logic             respcyc,
    input  logic             respack
);

    localparam int unsigned IDX_W  = $clog2(MEM_LINES);
    localparam int unsigned ADDR_W = IDX_W + SYSBUS_BEAT_W;
    localparam int unsigned LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned WR_POS = sysbus_tag_wr_pos(TAG_W);

    localparam logic [LAT_W-1:0]         LAT_INIT  = LAT_W'(LATENCY - 1);
    localparam logic [SYSBUS_BEAT_W-1:0] LAST_BEAT = SYSBUS_BEAT_W'(SYSBUS_BEATS - 1);

    sysbus_resp_state_t state_q, state_d;
    logic [IDX_W-1:0]         line_q, line_d;
    logic [TAG_W-1:0]         tag_q, tag_d;
    logic [SYSBUS_BEAT_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0]         lat_q, lat_d;
    logic                     reqack_q, reqack_d;
    logic                     respcyc_q, respcyc_d;
    sysbus_beat_t             resp_q, resp_d;
    logic [TAG_W-1:0]         resptag_q, resptag_d;

    logic [IDX_W-1:0]  req_idx_c;
    logic              ram_we_c;
    logic [ADDR_W-1:0] ram_waddr_c;
    logic [ADDR_W-1:0] ram_raddr_c;
    sysbus_beat_t      ram_rdata;

    assign req_idx_c = req[SYSBUS_OFFSET_W +: IDX_W];

    line_ram #(
        .MEM_LINES (MEM_LINES),
        .IDX_W     (IDX_W)
    ) u_line_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .waddr (ram_waddr_c),
        .wdata (req),
        .raddr (ram_raddr_c),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            line_q    <= '0;
            tag_q     <= '0;
            cnt_q     <= '0;
            lat_q     <= '0;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
            resptag_q <= '0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            tag_q     <= tag_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            reqack_q  <= reqack_d;
            respcyc_q <= respcyc_d;
            resp_q    <= resp_d;
            resptag_q <= resptag_d;
        end
    end

    // Next-state and RAM control; the read port always runs one beat ahead of resp.
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        tag_d       = tag_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        reqack_d    = 1'b0;
        respcyc_d   = respcyc_q;
        resp_d      = resp_q;
        resptag_d   = resptag_q;
        ram_we_c    = 1'b0;
        ram_waddr_c = {line_q, cnt_q};
        ram_raddr_c = {line_q, SYSBUS_BEAT_W'(0)};

        case (state_q)
            ST_IDLE: begin
                ram_raddr_c = {req_idx_c, SYSBUS_BEAT_W'(0)};
                if (reqcyc) begin
                    reqack_d = 1'b1;
                    line_d   = req_idx_c;
                    tag_d    = reqtag;
                    cnt_d    = '0;
                    if (reqtag[WR_POS]) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_WAIT;
                        lat_d   = LAT_INIT;
                    end
                end
            end

            ST_WDATA: begin
                // The beat seen during the reqack cycle is still the address beat.
                if (reqcyc && !reqack_q) begin
                    ram_we_c = 1'b1;
                    cnt_d    = SYSBUS_BEAT_W'(cnt_q + 1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_WAIT: begin
                if (lat_q == '0) begin
                    ram_raddr_c = {line_q, SYSBUS_BEAT_W'(1)};
                    state_d     = ST_RESP;
                    respcyc_d   = 1'b1;
                    resp_d      = ram_rdata;
                    resptag_d   = tag_q;
                    cnt_d       = '0;
                end else begin
                    lat_d = LAT_W'(lat_q - 1);
                end
            end

            ST_RESP: begin
                ram_raddr_c = {line_q, SYSBUS_BEAT_W'(cnt_q + 1)};
                if (respack) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d   = ST_IDLE;
                        respcyc_d = 1'b0;
                        resp_d    = '0;
                        resptag_d = '0;
                        cnt_d     = '0;
                    end else begin
                        resp_d      = ram_rdata;
                        cnt_d       = SYSBUS_BEAT_W'(cnt_q + 1);
                        ram_raddr_c = {line_q, SYSBUS_BEAT_W'(cnt_q + 2)};
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign reqack  = reqack_q;
    assign resp    = resp_q;
    assign resptag = resptag_q;
    assign respcyc = respcyc_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scoreboard bench for sysbus_mem_responder: directed line writes/reads, monitor compares every presented beat.
module tb_sysbus_mem_responder;

    localparam int unsigned MEM_LINES = 1024;
    localparam int unsigned LATENCY   = 4;
    localparam int unsigned TAG_W     = 13;

    typedef struct packed {
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [63:0]      req;
    logic [TAG_W-1:0] reqtag;
    logic             reqcyc;
    logic             reqack;
    logic [63:0]      resp;
    logic [TAG_W-1:0] resptag;
    logic             respcyc;
    logic             respack;

    exp_t        exp_q[$];
    logic [63:0] model [MEM_LINES][8];
    int          checks;
    int          errors;

    sysbus_mem_responder #(
        .MEM_LINES (MEM_LINES),
        .LATENCY   (LATENCY),
        .TAG_W     (TAG_W)
    ) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .req     (req),
        .reqtag  (reqtag),
        .reqcyc  (reqcyc),
        .reqack  (reqack),
        .resp    (resp),
        .resptag (resptag),
        .respcyc (respcyc),
        .respack (respack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Monitor: every cycle a beat is presented it must equal the queue head; pop on handshake.
    always @(negedge clk) begin
        if (rst_n && respcyc) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {63'd0, respcyc}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q[0];
                check("resp_data", resp, e.data);
                check("resp_tag", 64'(resptag), 64'(e.tag));
                if (respack) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send_addr(input logic [63:0] addr, input logic [TAG_W-1:0] tag, output bit ok);
        req    = addr;
        reqtag = tag;
        reqcyc = 1'b1;
        ok     = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk); #1;
            if (reqack) begin
                ok = 1'b1;
                check("reqack_latency", 64'(n), 64'd1);
                break;
            end
        end
        if (!ok) check("reqack_timeout", 64'd0, 64'd1);
        reqcyc = 1'b0;
    endtask

    task automatic write_line(input logic [63:0] addr, input logic [63:0] salt, input bit stall);
        bit ok;
        int idx;
        logic [63:0] v;
        idx = int'(addr[15:6]);
        send_addr(addr, 13'h1000, ok);
        // Junk beat on the reqack cycle must not be stored.
        req    = 64'hDEAD_BEEF_DEAD_BEEF;
        reqcyc = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            if (stall && k == 4) begin
                reqcyc = 1'b0;
                req    = 64'hBAD0_BAD0_BAD0_BAD0;
                repeat (2) begin @(posedge clk); #1; end
            end
            v = (64'h1111_1111_1111_1111 * 64'(k + 1)) ^ salt;
            model[idx][k] = v;
            req    = v;
            reqcyc = 1'b1;
            @(posedge clk); #1;
        end
        reqcyc = 1'b0;
    endtask

    task automatic wait_first_beat();
        int n;
        n = 0;
        while (!respcyc && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("first_beat_latency", 64'(n), 64'(LATENCY));
    endtask

    task automatic push_line(input int idx, input logic [TAG_W-1:0] tag);
        for (int k = 0; k < 8; k++) exp_q.push_back('{data: model[idx][k], tag: tag});
    endtask

    task automatic read_line(input logic [63:0] addr, input logic [TAG_W-1:0] tag,
                             input int stall_beat, input int stall_n, input int reset_beat);
        bit ok;
        push_line(int'(addr[15:6]), tag);
        respack = 1'b1;
        send_addr(addr, tag, ok);
        if (!ok) begin
            exp_q.delete();
            return;
        end
        wait_first_beat();
        for (int b = 0; b < 8; b++) begin
            if (b == reset_beat) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rst_respcyc", 64'(respcyc), 64'd0);
                check("rst_resp", resp, 64'd0);
                check("rst_reqack", 64'(reqack), 64'd0);
                exp_q.delete();
                respack = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                repeat (2) begin @(posedge clk); #1; end
                check("post_rst_respcyc", 64'(respcyc), 64'd0);
                return;
            end
            if (b == stall_beat) begin
                respack = 1'b0;
                repeat (stall_n) begin @(posedge clk); #1; end
                respack = 1'b1;
            end
            @(posedge clk); #1;
        end
        respack = 1'b0;
        check("respcyc_after_last", 64'(respcyc), 64'd0);
        check("beats_consumed", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic busy_test();
        bit ok;
        push_line(int'(64'h1000 >> 6), 13'h0011);
        respack = 1'b1;
        send_addr(64'h1000, 13'h0011, ok);
        if (!ok) begin
            exp_q.delete();
            return;
        end
        wait_first_beat();
        req    = 64'h2000;
        reqtag = 13'h0022;
        reqcyc = 1'b1;
        push_line(int'(64'h2000 >> 6), 13'h0022);
        for (int b = 0; b < 8; b++) begin
            check("busy_no_reqack", 64'(reqack), 64'd0);
            @(posedge clk); #1;
        end
        check("busy_idle_no_ack", 64'(reqack), 64'd0);
        @(posedge clk); #1;
        check("busy_reqack", 64'(reqack), 64'd1);
        reqcyc = 1'b0;
        wait_first_beat();
        for (int b = 0; b < 8; b++) begin @(posedge clk); #1; end
        respack = 1'b0;
        check("busy_respcyc_after_last", 64'(respcyc), 64'd0);
        check("busy_beats_consumed", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        req     = '0;
        reqtag  = '0;
        reqcyc  = 1'b0;
        respack = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("reset_reqack", 64'(reqack), 64'd0);
        check("reset_respcyc", 64'(respcyc), 64'd0);
        check("reset_resp", resp, 64'd0);
        check("reset_resptag", 64'(resptag), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        write_line(64'h1000, 64'd0, 1'b0);
        read_line(64'h1000, 13'h0042, -1, 0, -1);
        read_line(64'h1000, 13'h0043, 2, 3, -1);

        write_line(64'h2000, 64'hA5A5_0000_5A5A_FFFF, 1'b1);
        read_line(64'h2000, 13'h0100, -1, 0, -1);

        // Out-of-range address with offset bits set lands on line 1.
        write_line(64'h1007F, 64'h0F0F_0F0F_F0F0_F0F0, 1'b0);
        read_line(64'h40, 13'h0055, -1, 0, -1);

        busy_test();

        read_line(64'h2000, 13'h0066, -1, 0, 3);
        read_line(64'h2000, 13'h0077, -1, 0, -1);

        write_line(64'h1000, 64'hFFFF_0000_FFFF_0000, 1'b0);
        read_line(64'h1000, 13'h0088, -1, 0, -1);

        repeat (2) begin @(posedge clk); #1; end
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
